// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative unsigned
// multiply (shift-add) and restoring divide, with a start/done handshake.
module alu_seq #(
   parameter int WIDTH = 8,
   parameter int SW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [SW-1:0]    shamt,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] y_hi,
   output logic             zero,
   output logic             carry,
   output logic             ovf,
   output logic             dz,
   output logic             err
);

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_XOR  = 4'h4;
   localparam logic [3:0] OP_NOR  = 4'h5;
   localparam logic [3:0] OP_SLL  = 4'h6;
   localparam logic [3:0] OP_SRL  = 4'h7;
   localparam logic [3:0] OP_SRA  = 4'h8;
   localparam logic [3:0] OP_SLT  = 4'h9;
   localparam logic [3:0] OP_MULU = 4'hA;
   localparam logic [3:0] OP_DIVU = 4'hB;

   localparam logic [SW:0] CNT_INIT = (SW+1)'(WIDTH);
   localparam logic [SW:0] CNT_LAST = (SW+1)'(1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ITER = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [SW:0]      cnt_q, cnt_d;
   logic             is_mul_q, is_mul_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH:0]   hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic [WIDTH-1:0] y_hi_q, y_hi_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             dz_q, dz_d;
   logic             err_q, err_d;
   logic             done_q, done_d;

   // Single-cycle datapath works straight off the inputs sampled in IDLE.
   logic [WIDTH:0] add_full;
   logic [WIDTH:0] sub_full;
   logic           add_ovf;
   logic           sub_ovf;
   logic           slt;
   logic           go_iter;

   assign add_full = {1'b0, a} + {1'b0, b};
   assign sub_full = {1'b0, a} - {1'b0, b};
   assign add_ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
   assign sub_ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
   assign slt      = $signed(a) < $signed(b);
   assign go_iter  = (op == OP_MULU) || ((op == OP_DIVU) && (b != '0));

   // One iteration step. hi/lo hold partial product or remainder/quotient.
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   mul_acc;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_trial;
   logic             div_ok;
   logic [WIDTH:0]   step_hi;
   logic [WIDTH-1:0] step_lo;

   assign mul_sum   = hi_q + {1'b0, opnd_q};
   assign mul_acc   = lo_q[0] ? mul_sum : hi_q;
   assign div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
   assign div_trial = {1'b0, div_shift} - {2'b00, opnd_q};
   assign div_ok    = ~div_trial[WIDTH+1];
   assign step_hi   = is_mul_q ? {1'b0, mul_acc[WIDTH:1]}
                               : (div_ok ? div_trial[WIDTH:0] : div_shift);
   assign step_lo   = is_mul_q ? {mul_acc[0], lo_q[WIDTH-1:1]}
                               : {lo_q[WIDTH-2:0], div_ok};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_mul_d = is_mul_q;
      opnd_d   = opnd_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      y_d      = y_q;
      y_hi_d   = y_hi_q;
      zero_d   = zero_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      dz_d     = dz_q;
      err_d    = err_q;
      done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start && go_iter) begin
               // Results and flags keep their old values until completion.
               state_d  = S_ITER;
               cnt_d    = CNT_INIT;
               is_mul_d = (op == OP_MULU);
               opnd_d   = (op == OP_MULU) ? a : b;
               hi_d     = '0;
               lo_d     = (op == OP_MULU) ? b : a;
            end else if (start) begin
               done_d  = 1'b1;
               y_d     = '0;
               y_hi_d  = '0;
               carry_d = 1'b0;
               ovf_d   = 1'b0;
               dz_d    = 1'b0;
               err_d   = 1'b0;
               case (op)
                  OP_ADD: begin
                     y_d     = add_full[WIDTH-1:0];
                     carry_d = add_full[WIDTH];
                     ovf_d   = add_ovf;
                  end
                  OP_SUB: begin
                     y_d     = sub_full[WIDTH-1:0];
                     carry_d = sub_full[WIDTH];
                     ovf_d   = sub_ovf;
                  end
                  OP_AND:  y_d = a & b;
                  OP_OR:   y_d = a | b;
                  OP_XOR:  y_d = a ^ b;
                  OP_NOR:  y_d = ~(a | b);
                  OP_SLL:  y_d = a << shamt;
                  OP_SRL:  y_d = a >> shamt;
                  OP_SRA:  y_d = $unsigned($signed(a) >>> shamt);
                  OP_SLT:  y_d = {{(WIDTH-1){1'b0}}, slt};
                  OP_DIVU: begin
                     y_d    = '1;
                     y_hi_d = a;
                     dz_d   = 1'b1;
                  end
                  default: err_d = 1'b1;
               endcase
               zero_d = ~err_d & (y_d == '0);
            end
         end

         S_ITER: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - CNT_LAST;
            if (cnt_q == CNT_LAST) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               y_d     = step_lo;
               y_hi_d  = step_hi[WIDTH-1:0];
               carry_d = 1'b0;
               dz_d    = 1'b0;
               err_d   = 1'b0;
               if (is_mul_q) begin
                  zero_d = ({step_hi[WIDTH-1:0], step_lo} == '0);
                  ovf_d  = (step_hi[WIDTH-1:0] != '0);
               end else begin
                  zero_d = (step_lo == '0);
                  ovf_d  = 1'b0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         is_mul_q <= 1'b0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         y_q      <= '0;
         y_hi_q   <= '0;
         zero_q   <= 1'b0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         dz_q     <= 1'b0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_mul_q <= is_mul_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         y_q      <= y_d;
         y_hi_q   <= y_hi_d;
         zero_q   <= zero_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         dz_q     <= dz_d;
         err_q    <= err_d;
         done_q   <= done_d;
      end
   end

   assign busy  = (state_q == S_ITER);
   assign done  = done_q;
   assign y     = y_q;
   assign y_hi  = y_hi_q;
   assign zero  = zero_q;
   assign carry = carry_q;
   assign ovf   = ovf_q;
   assign dz    = dz_q;
   assign err   = err_q;

endmodule
